// File: rtl/kpyd_tone_pkg.sv
// Shared types and constants for the keypad tone controller.
package kpyd_tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } db_state_t;

    // Candidate encoding: bit 4 set marks an empty pass with every row high.
    localparam logic [4:0] KEY_NONE = 5'h10;

    // Phase steps for a 32-bit accumulator; only codes 0-7 produce a tone.
    localparam logic [31:0] STEP_TABLE [16] = '{
        32'h0165_5D3A, 32'h0191_5C60, 32'h01C2_0A50, 32'h01DD_7F9B,
        32'h0216_0CF8, 32'h0257_3A52, 32'h02A0_7A7B, 32'h02CA_BA74,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000
    };

endpackage

// File: rtl/kpyd_scan.sv
// Keypad column scanner: synchronizes rows, rotates the active-low column
// drive and reports the lowest pressed key code once per full pass.
module kpyd_scan
    import kpyd_tone_pkg::*;
#(
    parameter int scan_div_p = 1024
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] kpyd_row_i,
    output logic [3:0] kpyd_col_o,
    output logic       pass_done,
    output logic [4:0] cand
);

    localparam int              CNT_W    = (scan_div_p > 1) ? $clog2(scan_div_p) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(scan_div_p - 1);

    logic [3:0]       row_s1;
    logic [3:0]       row_s2;
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       col_idx;
    logic [4:0]       best_q;
    logic [4:0]       best_next;
    logic [1:0]       row_idx;
    logic             col_hit;

    assign kpyd_col_o = ~(4'b0001 << col_idx);

    // Two-flop row synchronizer; idles high so nothing looks pressed out of reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= kpyd_row_i;
            row_s2 <= row_s1;
        end
    end

    // Columns are visited in ascending order, so the first hit of a pass is the lowest code.
    always_comb begin
        row_idx = 2'd0;
        col_hit = 1'b0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_s2[r]) begin
                col_hit = 1'b1;
                row_idx = 2'(r);
            end
        end
        best_next = best_q;
        if (best_q[4] && col_hit) begin
            best_next = {1'b0, col_idx, row_idx};
        end
    end

    // Scan counter, column rotation and end-of-pass candidate hand-off.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            scan_cnt  <= '0;
            col_idx   <= 2'd0;
            best_q    <= KEY_NONE;
            cand      <= KEY_NONE;
            pass_done <= 1'b0;
        end else begin
            pass_done <= 1'b0;
            if (scan_cnt == CNT_LAST) begin
                scan_cnt <= '0;
                col_idx  <= col_idx + 2'd1;
                if (col_idx == 2'd3) begin
                    cand      <= best_next;
                    pass_done <= 1'b1;
                    best_q    <= KEY_NONE;
                end else begin
                    best_q <= best_next;
                end
            end else begin
                scan_cnt <= scan_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/kpyd_tone_ctrl.sv
// Keypad-driven tone controller: debounces scanned keys and hands the sine
// generator a phase step that only changes on stereo frame boundaries.
module kpyd_tone_ctrl
    import kpyd_tone_pkg::*;
#(
    parameter int scan_div_p = 1024,
    parameter int debounce_p = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [3:0]  kpyd_row_i,
    output logic [3:0]  kpyd_col_o,
    input  logic        frame_done_i,
    output logic [31:0] step_o,
    output logic        step_update_o,
    output logic        key_valid_o,
    output logic [3:0]  key_code_o
);

    localparam int              DB_W    = (debounce_p > 1) ? $clog2(debounce_p) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(debounce_p - 1);

    logic        pass_done;
    logic [4:0]  cand;
    db_state_t   db_state;
    logic [DB_W-1:0] db_cnt;
    logic [3:0]  press_code;
    logic [31:0] target;

    kpyd_scan #(
        .scan_div_p (scan_div_p)
    ) u_scan (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .kpyd_row_i (kpyd_row_i),
        .kpyd_col_o (kpyd_col_o),
        .pass_done  (pass_done),
        .cand       (cand)
    );

    // Match count holds passes seen so far minus nothing; the last match is detected
    // one short of debounce_p so the counter never needs to hold debounce_p itself.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            db_state    <= ST_IDLE;
            db_cnt      <= '0;
            press_code  <= 4'd0;
            key_valid_o <= 1'b0;
            key_code_o  <= 4'd0;
        end else if (pass_done) begin
            case (db_state)
                ST_IDLE: begin
                    if (!cand[4]) begin
                        db_state   <= ST_PRESS_DB;
                        press_code <= cand[3:0];
                        db_cnt     <= DB_W'(1);
                    end
                end
                ST_PRESS_DB: begin
                    if (cand[4]) begin
                        db_state <= ST_IDLE;
                        db_cnt   <= '0;
                    end else if (cand[3:0] == press_code) begin
                        if (db_cnt >= DB_LAST) begin
                            db_state    <= ST_HELD;
                            key_code_o  <= press_code;
                            key_valid_o <= 1'b1;
                            db_cnt      <= '0;
                        end else begin
                            db_cnt <= db_cnt + DB_W'(1);
                        end
                    end else begin
                        press_code <= cand[3:0];
                        db_cnt     <= DB_W'(1);
                    end
                end
                ST_HELD: begin
                    if (cand != {1'b0, key_code_o}) begin
                        db_state <= ST_RELEASE_DB;
                        db_cnt   <= DB_W'(1);
                    end
                end
                ST_RELEASE_DB: begin
                    if (cand == {1'b0, key_code_o}) begin
                        db_state <= ST_HELD;
                        db_cnt   <= '0;
                    end else if (db_cnt >= DB_LAST) begin
                        db_state    <= ST_IDLE;
                        key_valid_o <= 1'b0;
                        db_cnt      <= '0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                default: begin
                    db_state <= ST_IDLE;
                    db_cnt   <= '0;
                end
            endcase
        end
    end

    assign target = key_valid_o ? STEP_TABLE[key_code_o] : 32'd0;

    // Step only moves on a frame boundary, taking the target as it stood before that edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            step_o        <= 32'd0;
            step_update_o <= 1'b0;
        end else begin
            step_update_o <= 1'b0;
            if (frame_done_i && (target != step_o)) begin
                step_o        <= target;
                step_update_o <= 1'b1;
            end
        end
    end

endmodule
